// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- byte-wide UART transmitter (8N1, optionally 8E1).
//
// Accepts one byte per tx_valid/tx_ready handshake and shifts it out on tx as
// a start bit, eight data bits LSB first, an optional even-parity bit and one
// stop bit. Every bit is held for exactly BAUDRATE clk cycles, timed by an
// internal counter that starts at zero on the accept edge.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   -> PARITY state between DATA and STOP, tx carries the XOR of the
//                eight latched data bits (8E1, 11-bit frame).
//   undefined -> DATA goes straight to STOP (8N1, 10-bit frame).
//
// Parameters:
//   BAUDRATE  clk cycles per bit, 2..65535 (default 1302 = 50 MHz / 38400)
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous, active-low reset
//   tx_valid  tx_data holds a byte to send
//   tx_data   byte to send, sampled only on the accept edge
//   tx_ready  high exactly while the FSM is idle
//   tx        registered serial output, idles high
//   tx_busy   inverse of tx_ready
//   tx_done   one-cycle pulse in the cycle after the stop bit ends
// ---------------------------------------------------------------------------
module uart_tx #(
   parameter int unsigned BAUDRATE = 1302
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   // Last counter value of a bit period; compared at full 16-bit width.
   localparam logic [15:0] BIT_LAST = 16'(BAUDRATE - 1);

   logic [2:0]  state;
   logic [15:0] bit_cnt;
   logic [2:0]  idx;
   logic [7:0]  shreg;
   logic        bit_end;
`ifdef UART_TX_PARITY_EN
   // Parity is captured at accept time because shreg is consumed by shifting.
   logic        par_bit;
`endif

   assign bit_end  = (bit_cnt == BIT_LAST);
   assign tx_ready = (state == S_IDLE);
   assign tx_busy  = ~tx_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         idx     <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
         tx_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (tx_valid) begin
                  shreg   <= tx_data;
                  state   <= S_START;
                  bit_cnt <= '0;
                  tx      <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  par_bit <= ^tx_data;
`endif
               end
            end

            S_START: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  state   <= S_DATA;
                  idx     <= '0;
                  tx      <= shreg[0];
               end else begin
                  bit_cnt <= bit_cnt + 16'd1;
               end
            end

            S_DATA: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     state <= S_PARITY;
                     tx    <= par_bit;
`else
                     state <= S_STOP;
                     tx    <= 1'b1;
`endif
                  end else begin
                     idx   <= idx + 3'd1;
                     shreg <= {1'b0, shreg[7:1]};
                     // shreg[1] is the bit that becomes shreg[0] after this shift.
                     tx    <= shreg[1];
                  end
               end else begin
                  bit_cnt <= bit_cnt + 16'd1;
               end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  state   <= S_STOP;
                  tx      <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 16'd1;
               end
            end
`endif

            S_STOP: begin
               if (bit_end) begin
                  bit_cnt <= '0;
                  state   <= S_IDLE;
                  tx      <= 1'b1;
                  tx_done <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + 16'd1;
               end
            end

            default: begin
               // Unreachable encodings fall back to a quiet idle line.
               state   <= S_IDLE;
               bit_cnt <= '0;
               tx      <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx -- directed, self-checking bench for uart_tx with BAUDRATE = 4.
// Inputs change 1 time unit after the rising edge; outputs are checked at
// the same point, so each check sees the value held for that whole cycle.
// Cycle c of a frame is the c-th cycle after the accept edge.
// ---------------------------------------------------------------------------
module tb_uart_tx;

   localparam int unsigned B = 4;
`ifdef UART_TX_PARITY_EN
   localparam int unsigned FRAME = 11 * B;
`else
   localparam int unsigned FRAME = 10 * B;
`endif

   logic       clk;
   logic       reset;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   // Line monitors, sampled on the falling edge.
   int unsigned accepts  = 0;
   int unsigned dones    = 0;
   int unsigned high_run = 0;
   int unsigned last_run = 0;
   logic        prev_busy = 1'b0;
   logic        hold_valid = 1'b0;

   uart_tx #(.BAUDRATE(B)) dut (
      .clk      (clk),
      .reset    (reset),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready),
      .tx       (tx),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (tx_busy === 1'b1 && prev_busy === 1'b0) accepts++;
      prev_busy = tx_busy;
      if (tx_done === 1'b1) dones++;
      if (tx === 1'b1) begin
         high_run++;
      end else begin
         if (high_run != 0) last_run = high_run;
         high_run = 0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected line level for frame bit k (0 start, 1..8 data, parity, stop).
   function automatic logic exp_bit(input logic [7:0] d, input int unsigned k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_tx"},    tx,       1);
      check({tag, "_ready"}, tx_ready, 1);
      check({tag, "_busy"},  tx_busy,  0);
      check({tag, "_done"},  tx_done,  0);
   endtask

   // Presents a byte for one accept edge; returns in frame cycle 1.
   task automatic drive_byte(input logic [7:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      tick();
      tx_valid = hold_valid;
   endtask

   // Checks frame cycles 1..upto; when upto covers the whole frame, also
   // checks the completion cycle. inject_at pulses tx_valid with 0x3C.
   task automatic expect_frame(input logic [7:0] d, input int unsigned inject_at,
                               input int unsigned upto);
      for (int unsigned c = 1; c <= upto; c++) begin
         check($sformatf("tx_%02h_c%0d", d, c), tx, exp_bit(d, (c - 1) / B));
         check($sformatf("ready_%02h_c%0d", d, c), tx_ready, 0);
         check($sformatf("busy_%02h_c%0d", d, c), tx_busy, 1);
         check($sformatf("done_%02h_c%0d", d, c), tx_done, 0);
         tx_valid = hold_valid || (c == inject_at);
         if (c == inject_at) tx_data = 8'h3C;
         tick();
      end
      if (upto == FRAME) begin
         check($sformatf("done_end_%02h", d),  tx_done,  1);
         check($sformatf("ready_end_%02h", d), tx_ready, 1);
         check($sformatf("busy_end_%02h", d),  tx_busy,  0);
         check($sformatf("tx_end_%02h", d),    tx,       1);
      end
   endtask

   int unsigned acc0;
   int unsigned done0;

   initial begin
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      #2 reset = 1'b0;
      #1 check_idle("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Idle line
      for (int unsigned i = 0; i < 20; i++) check_idle($sformatf("idle%0d", i));

      // Single frame, one-cycle valid pulse
      acc0 = accepts; done0 = dones;
      drive_byte(8'hA5);
      expect_frame(8'hA5, 0, FRAME);
      tick();
      check_idle("after_a5");
      check("a5_accepts", accepts - acc0, 1);
      check("a5_dones",   dones - done0,  1);

      // Back-to-back with tx_valid held high
      acc0 = accepts; done0 = dones;
      hold_valid = 1'b1;
      drive_byte(8'h00);
      tx_data = 8'hFF;
      expect_frame(8'h00, 0, FRAME);
      tick();
      hold_valid = 1'b0;
      expect_frame(8'hFF, 0, FRAME);
      tick();
      check_idle("after_ff");
      check("b2b_gap",     last_run,       5);
      check("b2b_accepts", accepts - acc0, 2);
      check("b2b_dones",   dones - done0,  2);

      // Valid pulse mid-frame is ignored
      acc0 = accepts; done0 = dones;
      drive_byte(8'h55);
      expect_frame(8'h55, 12, FRAME);
      for (int unsigned i = 0; i < 8; i++) begin
         tick();
         check_idle($sformatf("after_55_%0d", i));
      end
      check("mid_accepts", accepts - acc0, 1);
      check("mid_dones",   dones - done0,  1);

      // Asynchronous reset in frame cycle 18 (a data-0 bit of 0xF0)
      done0 = dones;
      drive_byte(8'hF0);
      expect_frame(8'hF0, 0, 17);
      check("rst_pre_tx", tx, 0);
      #2 reset = 1'b0;
      #1 check_idle("rst_async");
      tick();
      tick();
      check_idle("rst_held");
      @(negedge clk);
      reset = 1'b1;
      for (int unsigned i = 0; i < 6; i++) begin
         tick();
         check_idle($sformatf("post_rst_%0d", i));
      end
      check("rst_no_done", dones - done0, 0);
      acc0 = accepts;
      drive_byte(8'h81);
      expect_frame(8'h81, 0, FRAME);
      check("rst_81_accepts", accepts - acc0, 1);

`ifdef UART_TX_PARITY_EN
      // Even parity: 0x07 -> 1, 0x03 -> 0
      tick();
      drive_byte(8'h07);
      expect_frame(8'h07, 0, FRAME);
      tick();
      drive_byte(8'h03);
      expect_frame(8'h03, 0, FRAME);
`endif

      tick();
      check_idle("final");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
